// File: rtl/mem_access_ctrl.sv
// Single-port memory initiator: arbitrates instruction fetch and datapath load/store
// onto one 16-bit synchronous memory, sequencing its one-cycle read latency and
// returning results with one-cycle ack pulses.
module mem_access_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MEM_DEPTH  = 257
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ack,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  access_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_val
);

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StRdIssue   = 2'd1;
    localparam logic [1:0] StRdCapture = 2'd2;
    localparam logic [1:0] StWr        = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  last_fetch_q, last_fetch_d;  // 1: last grant was FETCH
    logic                  rd_fetch_q, rd_fetch_d;      // owner of the in-flight read
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;
    logic                  mem_write_q, mem_write_d;
    logic                  fetch_ack_q, fetch_ack_d;
    logic                  data_ack_q, data_ack_d;
    logic                  access_err_q, access_err_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

    logic                  gnt_fetch;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  addr_bad;

    // Arbitration and access sequencing; acks/err/mem_write default low so they pulse.
    always_comb begin
        state_d       = state_q;
        last_fetch_d  = last_fetch_q;
        rd_fetch_d    = rd_fetch_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_write_d   = 1'b0;
        fetch_ack_d   = 1'b0;
        data_ack_d    = 1'b0;
        access_err_d  = 1'b0;
        fetch_data_d  = fetch_data_q;
        data_rdata_d  = data_rdata_q;
        gnt_fetch     = 1'b0;
        sel_addr      = '0;
        addr_bad      = 1'b0;

        case (state_q)
            StIdle: begin
                // An ack still high means its requester has not dropped req yet: bubble.
                if (!fetch_ack_q && !data_ack_q && (fetch_req || data_req)) begin
                    gnt_fetch    = (fetch_req && data_req) ? !last_fetch_q : fetch_req;
                    sel_addr     = gnt_fetch ? fetch_addr : data_addr;
                    addr_bad     = 32'(sel_addr) >= MEM_DEPTH;
                    last_fetch_d = gnt_fetch;
                    if (addr_bad) begin
                        // Rejected without touching the memory port.
                        access_err_d = 1'b1;
                        if (gnt_fetch) begin
                            fetch_ack_d  = 1'b1;
                            fetch_data_d = '0;
                        end else begin
                            data_ack_d = 1'b1;
                            if (!data_we) begin
                                data_rdata_d = '0;
                            end
                        end
                    end else if (!gnt_fetch && data_we) begin
                        mem_address_d = sel_addr;
                        mem_data_in_d = data_wdata;
                        mem_write_d   = 1'b1;
                        state_d       = StWr;
                    end else begin
                        mem_address_d = sel_addr;
                        rd_fetch_d    = gnt_fetch;
                        state_d       = StRdIssue;
                    end
                end
            end
            StRdIssue: begin
                state_d = StRdCapture;
            end
            StRdCapture: begin
                if (rd_fetch_q) begin
                    fetch_data_d = mem_val;
                    fetch_ack_d  = 1'b1;
                end else begin
                    data_rdata_d = mem_val;
                    data_ack_d   = 1'b1;
                end
                state_d = StIdle;
            end
            StWr: begin
                data_ack_d = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; async reset drops mem_write at once so an interrupted WR never writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            last_fetch_q  <= 1'b0;
            rd_fetch_q    <= 1'b0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_write_q   <= 1'b0;
            fetch_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
            access_err_q  <= 1'b0;
            fetch_data_q  <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            last_fetch_q  <= last_fetch_d;
            rd_fetch_q    <= rd_fetch_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_write_q   <= mem_write_d;
            fetch_ack_q   <= fetch_ack_d;
            data_ack_q    <= data_ack_d;
            access_err_q  <= access_err_d;
            fetch_data_q  <= fetch_data_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign fetch_ack   = fetch_ack_q;
    assign fetch_data  = fetch_data_q;
    assign data_ack    = data_ack_q;
    assign data_rdata  = data_rdata_q;
    assign access_err  = access_err_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural 257-word synchronous memory, a vector table
// of single accesses, scoreboard queues per requester, and hand-written sequences
// for reset, arbitration, held requests and store-then-fetch.
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_data;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic        access_err;
    logic [15:0] mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write;
    logic [15:0] mem_val;

    mem_access_ctrl #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .MEM_DEPTH (257)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_data (fetch_data),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_ack   (data_ack),
        .data_rdata (data_rdata),
        .access_err (access_err),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_write  (mem_write),
        .mem_val    (mem_val)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: one-cycle synchronous read, cleared while reset is held.
    logic [15:0] mem_arr [0:256];
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 257; i++) mem_arr[i] <= 16'h0;
            mem_val <= 16'h0;
        end else if (mem_address < 16'd257) begin
            if (mem_write) mem_arr[mem_address[8:0]] <= mem_data_in;
            mem_val <= mem_arr[mem_address[8:0]];
        end
    end

    typedef struct {
        logic        is_fetch;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic        exp_err;
        int          exp_lat;  // 0: not checked
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic        chk;
        logic        err;
    } exp_t;

    exp_t fetch_q[$];
    exp_t data_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    bit   wr_prev = 1'b0;
    bit   model_last_fetch = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ack pops the oldest expectation for its requester.
    always @(negedge clock) begin
        exp_t e;
        if (mem_write) begin
            wr_cnt++;
            check("mem_write_single_cycle", {31'b0, wr_prev}, 0);
        end
        wr_prev = mem_write;
        if (fetch_ack || data_ack) check("acks_exclusive", {31'b0, fetch_ack & data_ack}, 0);
        if (fetch_ack) begin
            check("fetch_ack_expected", 32'(fetch_q.size() > 0), 1);
            if (fetch_q.size() > 0) begin
                e = fetch_q.pop_front();
                check("fetch_data", {16'b0, fetch_data}, {16'b0, e.data});
                check("fetch_err", {31'b0, access_err}, {31'b0, e.err});
            end
        end
        if (data_ack) begin
            check("data_ack_expected", 32'(data_q.size() > 0), 1);
            if (data_q.size() > 0) begin
                e = data_q.pop_front();
                if (e.chk) check("data_rdata", {16'b0, data_rdata}, {16'b0, e.data});
                check("data_err", {31'b0, access_err}, {31'b0, e.err});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.data = v.exp_data;
        e.err  = v.exp_err;
        e.chk  = v.is_fetch || !v.we;
        return e;
    endfunction

    // Issue one access, wait (bounded) for its ack, drop req in the ack cycle.
    task automatic run_op(input vec_t v);
        int          cyc;
        logic        got;
        logic [15:0] a0;
        int          w0;
        a0 = mem_address;
        w0 = wr_cnt;
        if (v.is_fetch) begin
            fetch_q.push_back(mk_exp(v));
            fetch_req  = 1'b1;
            fetch_addr = v.addr;
        end else begin
            data_q.push_back(mk_exp(v));
            data_req   = 1'b1;
            data_we    = v.we;
            data_addr  = v.addr;
            data_wdata = v.wdata;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            got = v.is_fetch ? fetch_ack : data_ack;
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        model_last_fetch = v.is_fetch;
        check("ack_seen", {31'b0, got}, 1);
        if (got && v.exp_lat != 0) check("latency", cyc, v.exp_lat);
        if (v.exp_err) begin
            check("err_addr_hold", {16'b0, mem_address}, {16'b0, a0});
            check("err_no_write", wr_cnt, w0);
        end
    endtask

    vec_t tbl[12];

    initial begin
        logic [7:0] pattern;
        int         cyc;
        int         first;
        int         nacks;
        int         w0;
        vec_t       v;

        tbl[0]  = '{1'b1, 1'b0, 16'd0,    16'h0000, 16'h0000, 1'b0, 3};
        tbl[1]  = '{1'b0, 1'b1, 16'd5,    16'h1234, 16'h0000, 1'b0, 2};
        tbl[2]  = '{1'b0, 1'b0, 16'd5,    16'h0000, 16'h1234, 1'b0, 3};
        tbl[3]  = '{1'b0, 1'b1, 16'd256,  16'hBEEF, 16'h0000, 1'b0, 2};
        tbl[4]  = '{1'b1, 1'b0, 16'd256,  16'h0000, 16'hBEEF, 1'b0, 3};
        tbl[5]  = '{1'b0, 1'b0, 16'd257,  16'h0000, 16'h0000, 1'b1, 0};
        tbl[6]  = '{1'b0, 1'b1, 16'd300,  16'hFFFF, 16'h0000, 1'b1, 0};
        tbl[7]  = '{1'b0, 1'b0, 16'd300,  16'h0000, 16'h0000, 1'b1, 0};
        tbl[8]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 0};
        tbl[9]  = '{1'b0, 1'b0, 16'd5,    16'h0000, 16'h1234, 1'b0, 3};
        tbl[10] = '{1'b0, 1'b1, 16'd0,    16'hA5A5, 16'h0000, 1'b0, 2};
        tbl[11] = '{1'b1, 1'b0, 16'd0,    16'h0000, 16'hA5A5, 1'b0, 3};

        reset      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = 16'h0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = 16'h0;
        data_wdata = 16'h0;

        // Reset state, then reset asserted mid-RD_ISSUE.
        #3;
        check("reset_outputs_zero", {31'b0, |{fetch_ack, fetch_data, data_ack, data_rdata,
              access_err, mem_address, mem_data_in, mem_write}}, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        fetch_req  = 1'b1;
        fetch_addr = 16'd5;
        tick();
        check("mid_read_address", {16'b0, mem_address}, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs_zero", {31'b0, |{fetch_ack, fetch_data, data_ack,
              data_rdata, access_err, mem_address, mem_data_in, mem_write}}, 0);
        fetch_req = 1'b0;
        tick();
        tick();
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Single accesses from the table, one idle cycle between them.
        for (int i = 0; i < 12; i++) begin
            v = tbl[i];
            run_op(v);
            tick();
        end

        // Both requesters together three times: DATA first since the last grant was FETCH.
        for (int r = 0; r < 3; r++) begin
            fetch_q.push_back('{data: 16'h1234, chk: 1'b1, err: 1'b0});
            data_q.push_back('{data: 16'hBEEF, chk: 1'b1, err: 1'b0});
            fetch_req  = 1'b1;
            fetch_addr = 16'd5;
            data_req   = 1'b1;
            data_we    = 1'b0;
            data_addr  = 16'd256;
            first = 2;
            nacks = 0;
            cyc   = 0;
            while (nacks < 2 && cyc < 30) begin
                tick();
                cyc++;
                if (fetch_ack && fetch_req) begin
                    fetch_req = 1'b0;
                    if (first == 2) first = 1;
                    nacks++;
                end
                if (data_ack && data_req) begin
                    data_req = 1'b0;
                    if (first == 2) first = 0;
                    nacks++;
                end
            end
            check("arb_first_is_fetch", first, model_last_fetch ? 32'd0 : 32'd1);
            check("arb_both_acked", nacks, 2);
            fetch_req = 1'b0;
            data_req  = 1'b0;
            tick();
        end

        // fetch_req held two cycles past its ack: bubble, then one re-accepted read.
        fetch_q.push_back('{data: 16'h1234, chk: 1'b1, err: 1'b0});
        fetch_q.push_back('{data: 16'h1234, chk: 1'b1, err: 1'b0});
        fetch_req  = 1'b1;
        fetch_addr = 16'd5;
        cyc = 0;
        while (!fetch_ack && cyc < 20) begin
            tick();
            cyc++;
        end
        check("held_first_ack", {31'b0, fetch_ack}, 1);
        pattern = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            pattern[k-1] = fetch_ack;
            if (k == 2) fetch_req = 1'b0;
        end
        check("held_ack_pattern", {24'b0, pattern}, 32'h08);
        tick();

        // Store immediately followed by a fetch of the same word.
        w0 = wr_cnt;
        v = '{1'b0, 1'b1, 16'd7, 16'h5A5A, 16'h0000, 1'b0, 2};
        run_op(v);
        v = '{1'b1, 1'b0, 16'd7, 16'h0000, 16'h5A5A, 1'b0, 4};
        run_op(v);
        check("store_fetch_write_cycles", wr_cnt - w0, 1);

        repeat (4) tick();
        check("fetch_queue_drained", 32'(fetch_q.size()), 0);
        check("data_queue_drained", 32'(data_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
